// File: rtl/btb_retire_update_queue.sv
// -----------------------------------------------------------------------------
// btb_retire_update_queue
//
// Retire-side source for the BTB certified-update port. Resolved branch
// outcomes from retire are buffered in a small FIFO and drained to the BTB at
// one update per cycle. A cycle in which fetch1 performs a speculative BTB
// write never drains, because the BTB drops certified writes in that cycle.
// Overflow is non-fatal: BTB updates are only hints, so an outcome arriving
// while the queue is full is dropped and counted in a saturating counter.
//
// Configuration macro:
//   BTB_UPD_COALESCE_EN - when defined, a push whose PC equals the PC of the
//                         most recently pushed entry overwrites that entry's
//                         direction/target instead of allocating a new entry,
//                         provided the queue is non-empty and that entry is
//                         not being popped in the same cycle. A merge is taken
//                         even when the queue is full and never counts a drop.
//
// Ports:
//   clock, reset_n        clock, asynchronous active-low reset
//   ret_vld_i             retire presents a resolved branch this cycle
//   ret_brpc_i            branch PC
//   ret_brdir_i           resolved direction (1 = taken)
//   ret_brtar_i           resolved target
//   ret_rdy_o             queue not full (registered count only)
//   btb_spec_busy_i       BTB speculative write active this cycle
//   btb_we_cert_o         certified update strobe (head popped on this edge)
//   btb_brdir_cert_o      head direction (0 when empty)
//   btb_brtar_cert_o      head target    (0 when empty)
//   btb_brpc_cert_o       head PC        (0 when empty)
//   occ_o                 current entry count, 0..DEPTH
//   drop_cnt_o            saturating count of dropped retire outcomes
// -----------------------------------------------------------------------------
module btb_retire_update_queue #(
   parameter int DEPTH  = 8,
   parameter int DCNT_W = 16
) (
   input  logic                       clock,
   input  logic                       reset_n,
   input  logic                       ret_vld_i,
   input  logic [63:0]                ret_brpc_i,
   input  logic                       ret_brdir_i,
   input  logic [63:0]                ret_brtar_i,
   output logic                       ret_rdy_o,
   input  logic                       btb_spec_busy_i,
   output logic                       btb_we_cert_o,
   output logic                       btb_brdir_cert_o,
   output logic [63:0]                btb_brtar_cert_o,
   output logic [63:0]                btb_brpc_cert_o,
   output logic [$clog2(DEPTH):0]     occ_o,
   output logic [DCNT_W-1:0]          drop_cnt_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   // Entry storage: no reset, validity is tracked by the pointers/count.
   logic [63:0]       pc_q  [DEPTH];
   logic              dir_q [DEPTH];
   logic [63:0]       tar_q [DEPTH];

   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q,  count_d;
   logic [DCNT_W-1:0] drop_q,   drop_d;

   logic              nonempty_s;
   logic              full_s;
   logic              pop_s;
   logic              push_s;
   logic              drop_s;
   logic              merge_s;

   assign nonempty_s = (count_q != {CW{1'b0}});
   assign full_s     = (count_q == CW'(DEPTH));
   assign pop_s      = nonempty_s && !btb_spec_busy_i;

`ifdef BTB_UPD_COALESCE_EN
   logic [PW-1:0]     last_idx_s;
   logic              last_popping_s;

   // The most recently pushed entry sits just behind the write pointer; it is
   // the one being popped only when it is also the head, i.e. count == 1.
   assign last_idx_s     = wr_ptr_q - PW'(1);
   assign last_popping_s = pop_s && (count_q == CW'(1));
   assign merge_s        = ret_vld_i && nonempty_s && !last_popping_s &&
                           (pc_q[last_idx_s] == ret_brpc_i);
`else
   assign merge_s        = 1'b0;
`endif

   // A full queue drops even if the head pops this cycle: readiness is
   // decided from the registered count only.
   assign push_s = ret_vld_i && !full_s && !merge_s;
   assign drop_s = ret_vld_i &&  full_s && !merge_s;

   // Next-state computation for pointers, count and drop counter.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      drop_d   = drop_q;

      if (push_s) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end

      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end

      case ({push_s, pop_s})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      if (drop_s && (drop_q != {DCNT_W{1'b1}})) begin
         drop_d = drop_q + DCNT_W'(1);
      end else begin
         drop_d = drop_q;
      end
   end

   // Control state registers with asynchronous reset.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= {PW{1'b0}};
         rd_ptr_q <= {PW{1'b0}};
         count_q  <= {CW{1'b0}};
         drop_q   <= {DCNT_W{1'b0}};
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         drop_q   <= drop_d;
      end
   end

   // Entry array write: allocate at the write pointer, or merge into the tail.
`ifdef BTB_UPD_COALESCE_EN
   always_ff @(posedge clock) begin
      if (push_s) begin
         pc_q[wr_ptr_q]  <= ret_brpc_i;
         dir_q[wr_ptr_q] <= ret_brdir_i;
         tar_q[wr_ptr_q] <= ret_brtar_i;
      end else if (merge_s) begin
         dir_q[last_idx_s] <= ret_brdir_i;
         tar_q[last_idx_s] <= ret_brtar_i;
      end
   end
`else
   always_ff @(posedge clock) begin
      if (push_s) begin
         pc_q[wr_ptr_q]  <= ret_brpc_i;
         dir_q[wr_ptr_q] <= ret_brdir_i;
         tar_q[wr_ptr_q] <= ret_brtar_i;
      end
   end
`endif

   assign ret_rdy_o        = !full_s;
   assign btb_we_cert_o    = pop_s;
   assign btb_brpc_cert_o  = nonempty_s ? pc_q[rd_ptr_q]  : 64'd0;
   assign btb_brdir_cert_o = nonempty_s ? dir_q[rd_ptr_q] : 1'b0;
   assign btb_brtar_cert_o = nonempty_s ? tar_q[rd_ptr_q] : 64'd0;
   assign occ_o            = count_q;
   assign drop_cnt_o       = drop_q;

endmodule
